// File: rtl/cpu_result_pkg.sv
// Shared constants for the CPU result handoff: status/command bit positions and status packing.
package cpu_result_pkg;

  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_CNT_LSB   = 1;
  localparam int STAT_SEQ_LSB   = 4;
  localparam int STAT_CNT_W     = 3;

  localparam int CMD_ACK_BIT    = 0;
  localparam int CMD_FLUSH_BIT  = 7;

  localparam int SEQ_W          = 4;

  function automatic logic [7:0] packStatus(input logic             valid,
                                            input logic [STAT_CNT_W-1:0] cnt,
                                            input logic [SEQ_W-1:0]  seq);
    logic [7:0] stat;
    stat = 8'h00;
    stat[STAT_VALID_BIT]                       = valid;
    stat[STAT_CNT_LSB +: STAT_CNT_W]           = cnt;
    stat[STAT_SEQ_LSB +: SEQ_W]                = seq;
    return stat;
  endfunction

endpackage

// File: rtl/cpu_result_fifo.sv
// Small synchronous FIFO with push, pop and a synchronous clear; head word is read combinationally.
module cpu_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full && !i_clear;
  assign w_doPop  = i_pop && !o_empty && !i_clear;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_doPush && !w_doPop)      r_count <= r_count + CNT_W'(1);
      else if (w_doPop && !w_doPush) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/cpu_result_handoff.sv
// Buffers accelerator results for the Nios CPU; CPU pops by toggling done_read[0], flushes on a done_read[7] rise.
// Optional per-entry sequence numbers are built when CPU_RESULT_SEQ_EN is defined.
module cpu_result_handoff
  import cpu_result_pkg::*;
#(
  parameter int RESULT_W = 16,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                res_valid,
  input  logic [RESULT_W-1:0] res_data,
  output logic                res_ready,
  input  logic [7:0]          done_read,
  output logic [RESULT_W-1:0] result_out,
  output logic [7:0]          result_status
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef CPU_RESULT_SEQ_EN
  localparam int ENTRY_W = RESULT_W + SEQ_W;
`else
  localparam int ENTRY_W = RESULT_W;
`endif

  logic [7:0]            r_doneQ;
  logic                  r_ackErr;
  logic                  w_ackEvt;
  logic                  w_flushEvt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [ENTRY_W-1:0]    w_entryIn;
  logic [ENTRY_W-1:0]    w_head;
  logic [SEQ_W-1:0]      w_headSeq;
  logic [STAT_CNT_W-1:0] w_cntField;
  logic                  w_unusedCmd;

  // Edge detection against the previous PIO value: a new write flips bit 0, a flush raises bit 7.
  assign w_ackEvt    = done_read[CMD_ACK_BIT] ^ r_doneQ[CMD_ACK_BIT];
  assign w_flushEvt  = done_read[CMD_FLUSH_BIT] & ~r_doneQ[CMD_FLUSH_BIT];
  assign w_unusedCmd = ^r_doneQ[6:1];

  assign res_ready = !reset && !w_full && !w_flushEvt;
  assign w_push    = res_valid && res_ready;
  assign w_pop     = w_ackEvt && !w_empty && !w_flushEvt;

  always_ff @(posedge clk) begin
    if (reset) r_doneQ <= 8'h00;
    else       r_doneQ <= done_read;
  end

  // Acking an empty FIFO is sticky until a flush; a flush wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset)                     r_ackErr <= 1'b0;
    else if (w_flushEvt)           r_ackErr <= 1'b0;
    else if (w_ackEvt && w_empty)  r_ackErr <= 1'b1;
  end

`ifdef CPU_RESULT_SEQ_EN
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] w_seqNext;

  assign w_seqNext = r_seq + SEQ_W'(1);

  // Survives flushes so software can spot gaps across a flush.
  always_ff @(posedge clk) begin
    if (reset)       r_seq <= '0;
    else if (w_push) r_seq <= w_seqNext;
  end

  assign w_entryIn = {w_seqNext, res_data};
  assign w_headSeq = w_empty ? '0 : w_head[ENTRY_W-1 -: SEQ_W];
`else
  assign w_entryIn = res_data;
  assign w_headSeq = '0;
`endif

  cpu_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_flushEvt),
    .i_data  (w_entryIn),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cntField    = (w_empty && r_ackErr) ? 3'b111 : STAT_CNT_W'(w_count);
  assign result_out    = w_empty ? '0 : w_head[RESULT_W-1:0];
  assign result_status = packStatus(!w_empty, w_cntField, w_headSeq);

endmodule
